mbist_data_cmp: RTL and testbench

- Read-data checker directly downstream of the MBIST pattern selector.
- Delays the expected pattern and address to line up with memory read latency, then compares them against SRAM read data.
- Records a sticky fail flag, a saturating error count and the first failing address.
- Results are readable by the MBIST controller and shiftable on the MBIST scan chain.

---
 rtl/mbist_data_cmp_if.sv | 27 ++
 rtl/mbist_data_cmp.sv | 152 +++++++++++++++
 tb/tb_mbist_data_cmp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_data_cmp_if.sv
// mbist_data_cmp_if: read-side bus between the MBIST pattern selector / SRAM
// and the read-data checker.
//   cmp_en   - read issued this cycle; schedules a compare
//   cmp_inv  - expected data is ~pat_data for this read
//   pat_data - pattern from the selector
//   addr     - address of the issued read
//   rdata    - SRAM read data, valid BIST_RD_LAT cycles after cmp_en
// master: pattern selector / memory side (drives everything)
// slave : mbist_data_cmp
interface mbist_data_cmp_if #(
  parameter int unsigned BIST_ADDR_WD = 9,
  parameter int unsigned BIST_DATA_WD = 32
);
  logic                    cmp_en;
  logic                    cmp_inv;
  logic [BIST_DATA_WD-1:0] pat_data;
  logic [BIST_ADDR_WD-1:0] addr;
  logic [BIST_DATA_WD-1:0] rdata;

  modport master (
    output cmp_en, cmp_inv, pat_data, addr, rdata
  );

  modport slave (
    input cmp_en, cmp_inv, pat_data, addr, rdata
  );
endinterface

// File: rtl/mbist_data_cmp.sv
// mbist_data_cmp: MBIST read-data checker.
// Delays the expected pattern and read address by BIST_RD_LAT cycles so they
// line up with SRAM read data, compares, and records a sticky fail flag, a
// saturating error count and the first failing address. The result registers
// form a scan chain shifted LSB-out through sdo.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus          - mbist_data_cmp_if.slave (cmp_en, cmp_inv, pat_data, addr, rdata)
//   clear        - synchronous clear of result status
//   scan_shift   - scan shift enable (freezes pipeline, shifts status right)
//   sdi / sdo    - scan data in (enters chain MSB) / out (err_addr[0])
//   cmp_busy     - at least one compare in flight
//   cmp_fail     - one-cycle mismatch pulse
//   fail_sticky  - any mismatch since reset or clear
//   err_cnt      - saturating mismatch count
//   err_valid    - err_addr holds a captured address
//   err_addr     - first failing address
//   fail_mask    - (MBIST_CMP_FAIL_MASK_EN only) OR of failing bit positions
//
// Optional feature macro: MBIST_CMP_FAIL_MASK_EN
//   Adds fail_mask, placed at the MSB end of the scan chain.
module mbist_data_cmp #(
  parameter int unsigned BIST_ADDR_WD    = 9,
  parameter int unsigned BIST_DATA_WD    = 32,
  parameter int unsigned BIST_RD_LAT     = 1,
  parameter int unsigned BIST_ERR_CNT_WD = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mbist_data_cmp_if.slave            bus,
  input  logic                       clear,
  input  logic                       scan_shift,
  input  logic                       sdi,
  output logic                       sdo,
  output logic                       cmp_busy,
  output logic                       cmp_fail,
  output logic                       fail_sticky,
  output logic [BIST_ERR_CNT_WD-1:0] err_cnt,
  output logic                       err_valid,
  output logic [BIST_ADDR_WD-1:0]    err_addr
`ifdef MBIST_CMP_FAIL_MASK_EN
  ,
  output logic [BIST_DATA_WD-1:0]    fail_mask
`endif
);

`ifdef MBIST_CMP_FAIL_MASK_EN
  localparam int unsigned SCAN_WD = BIST_DATA_WD + 1 + BIST_ERR_CNT_WD + 1 + BIST_ADDR_WD;
`else
  localparam int unsigned SCAN_WD = 1 + BIST_ERR_CNT_WD + 1 + BIST_ADDR_WD;
`endif
  localparam int unsigned LAST = BIST_RD_LAT - 1;

  // Delay pipeline: one entry per cycle of read latency.
  logic [BIST_RD_LAT-1:0]                   pv;
  logic [BIST_RD_LAT-1:0][BIST_DATA_WD-1:0] pexp;
  logic [BIST_RD_LAT-1:0][BIST_ADDR_WD-1:0] paddr;

  logic [BIST_DATA_WD-1:0] exp_in;
  logic                    last_valid;
  logic [BIST_DATA_WD-1:0] last_exp;
  logic [BIST_ADDR_WD-1:0] last_addr;
  logic                    mismatch;
  logic [SCAN_WD-1:0]      chain_cur;
  logic [SCAN_WD-1:0]      chain_nxt;

  always_comb begin
    exp_in     = bus.cmp_inv ? ~bus.pat_data : bus.pat_data;
    last_valid = pv[LAST];
    last_exp   = pexp[LAST];
    last_addr  = paddr[LAST];
    mismatch   = last_valid & ~scan_shift & (bus.rdata != last_exp);
    cmp_busy   = |pv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv    <= '0;
      pexp  <= '0;
      paddr <= '0;
    end else if (!scan_shift) begin
      pv[0]    <= bus.cmp_en;
      pexp[0]  <= exp_in;
      paddr[0] <= bus.addr;
      for (int unsigned i = 1; i < BIST_RD_LAT; i++) begin
        pv[i]    <= pv[i-1];
        pexp[i]  <= pexp[i-1];
        paddr[i] <= paddr[i-1];
      end
    end
  end

  // Scan chain view of the status registers; shifting right moves sdi into
  // the MSB and presents err_addr[0] (chain bit 0) on sdo.
  always_comb begin
`ifdef MBIST_CMP_FAIL_MASK_EN
    chain_cur = {fail_mask, fail_sticky, err_cnt, err_valid, err_addr};
`else
    chain_cur = {fail_sticky, err_cnt, err_valid, err_addr};
`endif
    chain_nxt = {sdi, chain_cur[SCAN_WD-1:1]};
    sdo       = chain_cur[0];
  end

  // Priority: scan shift, then clear, then compare result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_fail    <= 1'b0;
      fail_sticky <= 1'b0;
      err_cnt     <= '0;
      err_valid   <= 1'b0;
      err_addr    <= '0;
`ifdef MBIST_CMP_FAIL_MASK_EN
      fail_mask   <= '0;
`endif
    end else if (scan_shift) begin
      cmp_fail <= 1'b0;
`ifdef MBIST_CMP_FAIL_MASK_EN
      {fail_mask, fail_sticky, err_cnt, err_valid, err_addr} <= chain_nxt;
`else
      {fail_sticky, err_cnt, err_valid, err_addr} <= chain_nxt;
`endif
    end else if (clear) begin
      cmp_fail    <= 1'b0;
      fail_sticky <= 1'b0;
      err_cnt     <= '0;
      err_valid   <= 1'b0;
      err_addr    <= '0;
`ifdef MBIST_CMP_FAIL_MASK_EN
      fail_mask   <= '0;
`endif
    end else begin
      cmp_fail <= mismatch;
      if (mismatch) begin
        fail_sticky <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
        // Only the first failing address is kept.
        if (!err_valid) begin
          err_valid <= 1'b1;
          err_addr  <= last_addr;
        end
`ifdef MBIST_CMP_FAIL_MASK_EN
        fail_mask <= fail_mask | (bus.rdata ^ last_exp);
`endif
      end
    end
  end

endmodule

// File: tb/tb_mbist_data_cmp.sv
// Directed bench for mbist_data_cmp: one instance at read latency 1 and one
// at read latency 2 share clock, reset, clear and scan controls.
module tb_mbist_data_cmp;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic scan_shift;
  logic sdi;

  always #5 clk = ~clk;

  mbist_data_cmp_if #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW)) b1 ();
  mbist_data_cmp_if #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW)) b2 ();

  logic          sdo1, busy1, fail1, sticky1, ev1;
  logic [CW-1:0] cnt1;
  logic [AW-1:0] ea1;
  logic          sdo2, busy2, fail2, sticky2, ev2;
  logic [CW-1:0] cnt2;
  logic [AW-1:0] ea2;
`ifdef MBIST_CMP_FAIL_MASK_EN
  logic [DW-1:0] mask1, mask2;
`endif

  mbist_data_cmp #(
    .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_RD_LAT(1), .BIST_ERR_CNT_WD(CW)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .clear(clear),
    .scan_shift(scan_shift), .sdi(sdi), .sdo(sdo1), .cmp_busy(busy1),
    .cmp_fail(fail1), .fail_sticky(sticky1), .err_cnt(cnt1),
    .err_valid(ev1), .err_addr(ea1)
`ifdef MBIST_CMP_FAIL_MASK_EN
    , .fail_mask(mask1)
`endif
  );

  mbist_data_cmp #(
    .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_RD_LAT(2), .BIST_ERR_CNT_WD(CW)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave), .clear(clear),
    .scan_shift(scan_shift), .sdi(sdi), .sdo(sdo2), .cmp_busy(busy2),
    .cmp_fail(fail2), .fail_sticky(sticky2), .err_cnt(cnt2),
    .err_valid(ev2), .err_addr(ea2)
`ifdef MBIST_CMP_FAIL_MASK_EN
    , .fail_mask(mask2)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [14:0] exp_chain;

    rst_n = 1'b0; clear = 1'b0; scan_shift = 1'b0; sdi = 1'b0;
    b1.cmp_en = 1'b0; b1.cmp_inv = 1'b0; b1.pat_data = '0; b1.addr = '0; b1.rdata = '0;
    b2.cmp_en = 1'b0; b2.cmp_inv = 1'b0; b2.pat_data = '0; b2.addr = '0; b2.rdata = '0;
    #12;
    // Reset state
    chk("rst_fail1", 64'(fail1), 64'(0));
    chk("rst_busy1", 64'(busy1), 64'(0));
    chk("rst_cnt1", 64'(cnt1), 64'(0));
    chk("rst_fail2", 64'(fail2), 64'(0));
    chk("rst_sticky2", 64'(sticky2), 64'(0));
    chk("rst_ev2", 64'(ev2), 64'(0));
    chk("rst_ea2", 64'(ea2), 64'(0));
    chk("rst_sdo2", 64'(sdo2), 64'(0));
    rst_n = 1'b1;
    tick;

    // Latency 1: eight matching back-to-back reads
    b1.pat_data = 32'hAAAA_5555;
    b1.rdata    = 32'hAAAA_5555;
    for (int i = 0; i < 8; i++) begin
      b1.cmp_en = 1'b1;
      b1.addr   = 9'(i);
      tick;
      chk("a_fail", 64'(fail1), 64'(0));
    end
    b1.cmp_en = 1'b0;
    chk("a_busy_tail", 64'(busy1), 64'(1));
    tick;
    chk("a_busy_idle", 64'(busy1), 64'(0));
    chk("a_fail_end", 64'(fail1), 64'(0));
    chk("a_cnt", 64'(cnt1), 64'(0));
    chk("a_sticky", 64'(sticky1), 64'(0));

    // Latency 2: reads 010..013, only 012 returns bad data
    b2.pat_data = 32'h1234_5678;
    b2.cmp_inv  = 1'b0;
    for (int n = 0; n < 7; n++) begin
      b2.cmp_en = (n < 4);
      b2.addr   = 9'(16 + n);
      b2.rdata  = (n == 4) ? 32'h1234_5679 : 32'h1234_5678;
      tick;
      chk("b_fail", 64'(fail2), 64'(n == 4));
    end
    chk("b_cnt", 64'(cnt2), 64'(1));
    chk("b_ea", 64'(ea2), 64'(9'h012));
    chk("b_ev", 64'(ev2), 64'(1));
    chk("b_sticky", 64'(sticky2), 64'(1));
    chk("b_busy", 64'(busy2), 64'(0));
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("b_clr_sticky", 64'(sticky2), 64'(0));
    chk("b_clr_cnt", 64'(cnt2), 64'(0));
    chk("b_clr_ev", 64'(ev2), 64'(0));
    chk("b_clr_ea", 64'(ea2), 64'(0));

    // cmp_inv: inverted read matches, plain read with same data fails
    b2.pat_data = 32'h0000_FFFF;
    b2.rdata    = 32'hFFFF_0000;
    for (int n = 0; n < 5; n++) begin
      b2.cmp_en  = (n < 2);
      b2.cmp_inv = (n == 0);
      b2.addr    = 9'(32 + n);
      tick;
      chk("c_fail", 64'(fail2), 64'(n == 3));
    end
    chk("c_cnt", 64'(cnt2), 64'(1));
    chk("c_ea", 64'(ea2), 64'(9'h021));
    clear = 1'b1;
    tick;
    clear = 1'b0;

    // 20 consecutive mismatches: saturation and first address retained
    b2.pat_data = 32'h0000_0000;
    b2.cmp_inv  = 1'b0;
    b2.rdata    = 32'h0000_0001;
    for (int i = 0; i < 22; i++) begin
      b2.cmp_en = (i < 20);
      b2.addr   = 9'(64 + i);
      tick;
      if (i == 15) chk("d_cnt_e", 64'(cnt2), 64'(4'hE));
      if (i == 16) chk("d_cnt_f", 64'(cnt2), 64'(4'hF));
    end
    chk("d_cnt_sat", 64'(cnt2), 64'(4'hF));
    chk("d_ea", 64'(ea2), 64'(9'h040));
    chk("d_ev", 64'(ev2), 64'(1));

    // clear coincident with a mismatch; next in-flight mismatch records
    b2.cmp_en = 1'b1; b2.addr = 9'h050; tick;
    b2.cmp_en = 1'b1; b2.addr = 9'h051; tick;
    b2.cmp_en = 1'b0; clear = 1'b1; tick;
    chk("e_fail", 64'(fail2), 64'(0));
    chk("e_sticky", 64'(sticky2), 64'(0));
    chk("e_cnt", 64'(cnt2), 64'(0));
    chk("e_ev", 64'(ev2), 64'(0));
    chk("e_ea", 64'(ea2), 64'(0));
    clear = 1'b0;
    tick;
    chk("e_fail2", 64'(fail2), 64'(1));
    chk("e_cnt2", 64'(cnt2), 64'(1));
    chk("e_ea2", 64'(ea2), 64'(9'h051));
    chk("e_ev2", 64'(ev2), 64'(1));
    tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;

    // Three fails from 1F8, then scan the status out
    b2.pat_data = 32'h0000_0000;
    b2.rdata    = 32'h0000_0100;
    for (int n = 0; n < 5; n++) begin
      b2.cmp_en = (n < 3);
      b2.addr   = 9'(9'h1F8 + n);
      tick;
    end
    chk("f_cnt", 64'(cnt2), 64'(3));
    chk("f_ea", 64'(ea2), 64'(9'h1F8));
    chk("f_sticky", 64'(sticky2), 64'(1));
`ifdef MBIST_CMP_FAIL_MASK_EN
    chk("f_mask", 64'(mask2), 64'(32'h0000_0100));
`endif
    exp_chain  = {1'b1, 4'd3, 1'b1, 9'h1F8};
    scan_shift = 1'b1;
    sdi        = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk("f_sdo", 64'(sdo2), 64'(exp_chain[k]));
      tick;
      chk("f_fail_shift", 64'(fail2), 64'(0));
    end
`ifdef MBIST_CMP_FAIL_MASK_EN
    for (int k = 0; k < 32; k++) begin
      chk("f_sdo_mask", 64'(sdo2), 64'(k == 8));
      tick;
    end
`endif
    scan_shift = 1'b0;
    sdi        = 1'b0;
    chk("f_shift_sticky", 64'(sticky2), 64'(1));
    chk("f_shift_cnt", 64'(cnt2), 64'(4'hF));
    chk("f_shift_ev", 64'(ev2), 64'(1));
    chk("f_shift_ea", 64'(ea2), 64'(9'h1FF));

    // Asynchronous reset with a compare in flight
    b2.cmp_en = 1'b1; b2.addr = 9'h0AA; b2.rdata = 32'h0000_0001;
    tick;
    b2.cmp_en = 1'b0;
    chk("g_busy_pre", 64'(busy2), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("g_busy_rst", 64'(busy2), 64'(0));
    chk("g_cnt_rst", 64'(cnt2), 64'(0));
    chk("g_ea_rst", 64'(ea2), 64'(0));
    chk("g_sticky_rst", 64'(sticky2), 64'(0));
    #2 rst_n = 1'b1;
    tick;
    tick;
    chk("g_fail_after", 64'(fail2), 64'(0));
    chk("g_cnt_after", 64'(cnt2), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
